// File: rtl/multi_pulse_generator.sv
// Multi-channel periodic pulse generator with per-channel shadow/active config sets.
// Optional burst mode (cfg_count, DONE state, done output) is built when PULSE_GEN_BURST_EN is defined.
module multi_pulse_generator #(
    parameter int CH = 2,
    parameter int CW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            cfg_we,
    input  logic [2:0]      cfg_ch,
    input  logic [CW-1:0]   cfg_period,
    input  logic [CW-1:0]   cfg_width,
    input  logic [CW-1:0]   cfg_phase,
    input  logic [CW-1:0]   cfg_count,
    output logic [CH-1:0]   pulse_out,
    output logic [CH-1:0]   done,
    output logic [2*CH-1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW-1:0] C_P_RST = CW'(128);

`ifndef PULSE_GEN_BURST_EN
    logic w_cfg_count_unused;
    assign w_cfg_count_unused = ^cfg_count;
`endif

    for (genvar c = 0; c < CH; c++) begin : g_ch
        localparam logic [2:0] C_IDX = 3'(c);

        state_t        r_state;
        state_t        w_state_nxt;
        logic [CW-1:0] r_sh_p, r_sh_w, r_sh_d;
        logic [CW-1:0] r_act_p, r_act_w, r_act_d;
        logic [CW-1:0] r_cnt, w_cnt_nxt;
        logic [CW-1:0] w_p_nxt, w_w_nxt;
        logic          w_wr, w_boundary, w_load, w_pulse_nxt, r_pulse;
`ifdef PULSE_GEN_BURST_EN
        logic [CW-1:0] r_sh_n, r_act_n, r_pcnt, w_pcnt_nxt, w_pcnt_inc;
        logic          w_done_nxt, r_done;
`endif

        assign w_wr   = cfg_we && (cfg_ch == C_IDX);
        // Active P/W follow the shadow while idle and at every period boundary.
        assign w_load = (r_state == S_IDLE) || w_boundary;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sh_p <= C_P_RST;
                r_sh_w <= C_ONE;
                r_sh_d <= '0;
            end else if (w_wr) begin
                r_sh_p <= cfg_period;
                r_sh_w <= cfg_width;
                r_sh_d <= cfg_phase;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_act_p <= C_P_RST;
                r_act_w <= C_ONE;
                r_act_d <= '0;
            end else begin
                if (w_load) begin
                    r_act_p <= r_sh_p;
                    r_act_w <= r_sh_w;
                end
                if (r_state == S_IDLE) begin
                    r_act_d <= r_sh_d;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_pulse <= w_pulse_nxt;
            end
        end

`ifdef PULSE_GEN_BURST_EN
        // pcnt saturates rather than wrapping in continuous mode.
        assign w_pcnt_inc = (r_pcnt == '1) ? r_pcnt : r_pcnt + C_ONE;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sh_n  <= '0;
                r_act_n <= '0;
                r_pcnt  <= '0;
                r_done  <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_sh_n <= cfg_count;
                end
                if (r_state == S_IDLE) begin
                    r_act_n <= r_sh_n;
                end
                r_pcnt <= w_pcnt_nxt;
                r_done <= w_done_nxt;
            end
        end
`endif

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_boundary  = 1'b0;
`ifdef PULSE_GEN_BURST_EN
            w_pcnt_nxt  = r_pcnt;
`endif
            if (!run) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
`ifdef PULSE_GEN_BURST_EN
                w_pcnt_nxt  = '0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // The phase decision uses the shadow value being copied on this edge.
                        if (r_sh_d != '0) begin
                            w_state_nxt = S_DELAY;
                            w_cnt_nxt   = C_ONE;
                        end else begin
                            w_state_nxt = S_RUN;
                            w_cnt_nxt   = '0;
                        end
                    end
                    S_DELAY: begin
                        if (r_cnt == r_act_d) begin
                            w_state_nxt = S_RUN;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + C_ONE;
                        end
                    end
                    S_RUN: begin
                        if (r_act_p == '0) begin
                            w_cnt_nxt = '0;
                        end else if (r_cnt == r_act_p - C_ONE) begin
                            w_boundary = 1'b1;
                            w_cnt_nxt  = '0;
`ifdef PULSE_GEN_BURST_EN
                            w_pcnt_nxt = w_pcnt_inc;
                            if ((r_act_n != '0) && (w_pcnt_inc == r_act_n)) begin
                                w_state_nxt = S_DONE;
                            end
`endif
                        end else begin
                            w_cnt_nxt = r_cnt + C_ONE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end

        // Outputs are registered, so they are decoded from the next state and next active set.
        always_comb begin
            w_p_nxt     = w_load ? r_sh_p : r_act_p;
            w_w_nxt     = w_load ? r_sh_w : r_act_w;
            w_pulse_nxt = (w_state_nxt == S_RUN) && (w_p_nxt != '0) && (w_cnt_nxt < w_w_nxt);
`ifdef PULSE_GEN_BURST_EN
            w_done_nxt  = (w_state_nxt == S_DONE);
`endif
        end

        assign pulse_out[c]          = r_pulse;
        assign o_dbg_state[2*c +: 2] = r_state;
`ifdef PULSE_GEN_BURST_EN
        assign done[c]               = r_done;
`else
        assign done[c]               = 1'b0;
`endif
    end

endmodule

// File: tb/tb_multi_pulse_generator.sv
// Directed bench for multi_pulse_generator (CH=2, CW=16): pulse trains, phase, live reconfig,
// edge widths, run drop, async reset and (with PULSE_GEN_BURST_EN) burst termination.
module tb_multi_pulse_generator;

    localparam int CH = 2;
    localparam int CW = 16;
`ifdef PULSE_GEN_BURST_EN
    localparam int BURST = 1;
`else
    localparam int BURST = 0;
`endif

    logic            clk;
    logic            rst_n;
    logic            run;
    logic            cfg_we;
    logic [2:0]      cfg_ch;
    logic [CW-1:0]   cfg_period, cfg_width, cfg_phase, cfg_count;
    logic [CH-1:0]   pulse_out;
    logic [CH-1:0]   done;
    logic [2*CH-1:0] o_dbg_state;

    // Each entry is {done[1], done[0], pulse_out[1], pulse_out[0]} for one sampled cycle.
    logic [2*CH-1:0] exp_q[$];
    int n_checks;
    int n_pass;

    multi_pulse_generator #(.CH(CH), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_width   (cfg_width),
        .cfg_phase   (cfg_phase),
        .cfg_count   (cfg_count),
        .pulse_out   (pulse_out),
        .done        (done),
        .o_dbg_state (o_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Expected {done, pulse} of one channel k cycles after the run edge.
    function automatic logic [1:0] exp_ch(input int k, input int p, input int w, input int d, input int nb);
        if (p > 0 && nb > 0 && k >= d + nb * p) return 2'b10;
        if (p == 0 || k < d) return 2'b00;
        return {1'b0, ((k - d) % p) < w};
    endfunction

    task automatic push_seg(input int n, input int p0, input int w0, input int d0, input int n0,
                            input int p1, input int w1, input int d1, input int n1);
        for (int k = 0; k < n; k++) begin
            logic [1:0] e0, e1;
            e0 = exp_ch(k, p0, w0, d0, n0);
            e1 = exp_ch(k, p1, w1, d1, n1);
            exp_q.push_back({e1[1], e0[1], e1[0], e0[0]});
        end
    endtask

    task automatic tick(input string tag);
        logic [2*CH-1:0] e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check({tag, "_exp_q_size"}, exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            check(tag, {done, pulse_out}, e);
        end
    endtask

    task automatic run_seg(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic cfg_drive(input int ch, input int p, input int w, input int d, input int nb);
        cfg_ch     = 3'(ch);
        cfg_period = CW'(p);
        cfg_width  = CW'(w);
        cfg_phase  = CW'(d);
        cfg_count  = CW'(nb);
        cfg_we     = 1'b1;
    endtask

    task automatic idle_write(input int ch, input int p, input int w, input int d, input int nb);
        cfg_drive(ch, p, w, d, nb);
        push_seg(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("idle_wr");
        cfg_we = 1'b0;
    endtask

    task automatic stop_run(input string tag);
        run = 1'b0;
        push_seg(2, 0, 0, 0, 0, 0, 0, 0, 0);
        run_seg(tag, 2);
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        run        = 1'b0;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_period = '0;
        cfg_width  = '0;
        cfg_phase  = '0;
        cfg_count  = '0;

        @(negedge clk);
        check("rst_pulse", pulse_out, 0);
        check("rst_done", done, 0);
        check("rst_state", o_dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset defaults: one high cycle every 128 cycles, first on the run edge.
        run = 1'b1;
        push_seg(260, 128, 1, 0, 0, 128, 1, 0, 0);
        run_seg("dflt", 260);
        stop_run("dflt_stop");

        // Phase offset: ch1 lags ch0 by 4 cycles, both period 10.
        idle_write(0, 10, 3, 0, 0);
        idle_write(1, 10, 3, 4, 0);
        run = 1'b1;
        push_seg(40, 10, 3, 0, 0, 10, 3, 4, 0);
        tick("phase");
        check("phase_state_k0", o_dbg_state, 4'b0110);
        run_seg("phase", 39);
        stop_run("phase_stop");

        // Mid-period write: current 8-cycle period completes, then 5/4 takes over. ch1 P=0 stays low.
        idle_write(0, 8, 2, 0, 0);
        idle_write(1, 0, 3, 0, 0);
        run = 1'b1;
        push_seg(8, 8, 2, 0, 0, 0, 3, 0, 0);
        push_seg(20, 5, 4, 0, 0, 0, 3, 0, 0);
        run_seg("midwr", 3);
        cfg_drive(0, 5, 4, 0, 0);
        tick("midwr");
        cfg_we = 1'b0;
        run_seg("midwr", 24);
        stop_run("midwr_stop");

        // Write on the boundary edge itself: adopted one period later.
        idle_write(0, 8, 2, 0, 0);
        run = 1'b1;
        push_seg(16, 8, 2, 0, 0, 0, 3, 0, 0);
        push_seg(12, 5, 4, 0, 0, 0, 3, 0, 0);
        run_seg("bndwr", 8);
        cfg_drive(0, 5, 4, 0, 0);
        tick("bndwr");
        cfg_we = 1'b0;
        run_seg("bndwr", 19);
        stop_run("bndwr_stop");

        // W=0 never high, W=P continuously high.
        idle_write(0, 6, 0, 0, 0);
        idle_write(1, 6, 6, 0, 0);
        run = 1'b1;
        push_seg(20, 6, 0, 0, 0, 6, 6, 0, 0);
        run_seg("wedge", 20);
        stop_run("wedge_stop");

        // Drop run while both channels are high, then restart from a new phase.
        idle_write(0, 10, 5, 0, 0);
        idle_write(1, 10, 5, 2, 0);
        run = 1'b1;
        push_seg(3, 10, 5, 0, 0, 10, 5, 2, 0);
        run_seg("drop", 3);
        stop_run("drop_clr");
        idle_write(0, 6, 2, 3, 0);
        run = 1'b1;
        push_seg(20, 6, 2, 3, 0, 10, 5, 2, 0);
        run_seg("restart", 20);
        stop_run("restart_stop");

        // Burst of 3 on ch0 (done from cycle 24); ch1 continuous. Without burst support both run on.
        idle_write(0, 8, 2, 0, 3);
        idle_write(1, 8, 2, 0, 0);
        run = 1'b1;
        push_seg(40, 8, 2, 0, 3 * BURST, 8, 2, 0, 0);
        run_seg("burst", 40);
        stop_run("burst_clr");

        // Asynchronous reset mid-pulse, then defaults come back.
        idle_write(0, 10, 8, 0, 0);
        run = 1'b1;
        push_seg(3, 10, 8, 0, 0, 8, 2, 0, 0);
        run_seg("pre_rst", 3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_pulse", pulse_out, 0);
        check("arst_done", done, 0);
        check("arst_state", o_dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        push_seg(6, 128, 1, 0, 0, 128, 1, 0, 0);
        run_seg("post_rst", 6);
        check("exp_q_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
